// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: iterative multiply/divide sequencer owning the HI/LO pair.
// A 32-step shift-add multiplier and a 32-step restoring divider work on
// operand magnitudes. Signs are re-applied in FIN, just before the write-back.
//
// Handshake: start is sampled only while stall is low (IDLE). The execute
// stage holds the pipeline while stall is high. done (and divZero for a
// zero divisor) pulses for exactly one cycle. HI/LO show the new values on
// the cycle after done. cancel drops the running operation without a write.
module hilo_md_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mdOp,
  input  logic [WIDTH-1:0] regaData,
  input  logic [WIDTH-1:0] regbData,
  input  logic             whi,
  input  logic             wlo,
  input  logic [WIDTH-1:0] wHiData,
  input  logic [WIDTH-1:0] wLoData,
  input  logic             cancel,
  output logic             stall,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] rHiData,
  output logic [WIDTH-1:0] rLoData,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIN = 2'd3} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   mcand, mplier, rem, quot, divisor;
  logic [2*WIDTH-1:0] acc;
  logic [5:0]         cnt;
  logic               neg_res, neg_rem, is_div, zero_flag;

  // Operand decode for the start cycle.
  logic             op_signed, rs_neg, rt_neg, rt_zero, last_iter;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign op_signed = ~mdOp[0];
  assign rs_neg    = op_signed & regaData[WIDTH-1];
  assign rt_neg    = op_signed & regbData[WIDTH-1];
  assign rs_mag    = rs_neg ? -regaData : regaData;
  assign rt_mag    = rt_neg ? -regbData : regbData;
  assign rt_zero   = (regbData == '0);
  assign last_iter = (cnt == 6'(WIDTH - 1));

  // One multiply step: the add result keeps its carry so the right shift is WIDTH+1 bits wide.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);

  // One divide step. rem < divisor always holds, so the trial fits in WIDTH+1 bits as a signed value.
  logic [WIDTH:0] rem_sh, div_trial;
  logic           div_ge;
  assign rem_sh    = {rem, quot[WIDTH-1]};
  assign div_trial = rem_sh - {1'b0, divisor};
  assign div_ge    = ~div_trial[WIDTH];

  // Signed results, formed from the magnitudes.
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quot_f, rem_f;
  assign prod_f = neg_res ? -acc  : acc;
  assign quot_f = neg_res ? -quot : quot;
  assign rem_f  = neg_rem ? -rem  : rem;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. cancel takes priority over the iteration count and over the FIN write-back.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) begin
        if (!mdOp[1])    state_nxt = S_MUL;
        else if (rt_zero) state_nxt = S_FIN;
        else              state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (cancel)         state_nxt = S_IDLE;
        else if (last_iter) state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state. cancel suppresses done while in FIN.
  always_comb begin
    stall     = (state != S_IDLE);
    done      = (state == S_FIN) && !cancel;
    divZero   = (state == S_FIN) && !cancel && zero_flag;
    state_dbg = state;
  end

  // Datapath: latch the operands on start, then do one multiply or divide step per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      rem       <= '0;
      quot      <= '0;
      divisor   <= '0;
      cnt       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      is_div    <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mcand     <= rs_mag;
          mplier    <= rt_mag;
          acc       <= '0;
          rem       <= '0;
          quot      <= rs_mag;
          divisor   <= rt_mag;
          cnt       <= '0;
          neg_res   <= rs_neg ^ rt_neg;
          neg_rem   <= (mdOp == 2'b10) & regaData[WIDTH-1];
          is_div    <= mdOp[1];
          zero_flag <= mdOp[1] & rt_zero;
        end
        S_MUL: begin
          acc    <= {mul_sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          if (!last_iter) cnt <= cnt + 6'd1;
        end
        S_DIV: begin
          rem  <= div_ge ? div_trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quot <= {quot[WIDTH-2:0], div_ge};
          if (!last_iter) cnt <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // HI/LO: direct writes only in IDLE. The result is written when FIN exits without a cancel or a zero divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rHiData <= '0;
      rLoData <= '0;
    end else if (state == S_IDLE) begin
      if (whi) rHiData <= wHiData;
      if (wlo) rLoData <= wLoData;
    end else if (state == S_FIN && !cancel && !zero_flag) begin
      if (is_div) begin
        rHiData <= rem_f;
        rLoData <= quot_f;
      end else begin
        rHiData <= prod_f[2*WIDTH-1:WIDTH];
        rLoData <= prod_f[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Bench for hilo_md_ctrl. A behavioural model predicts stall, done, divZero
// and HI/LO every cycle. It works from a busy countdown and from 64-bit
// arithmetic results. Directed sequences pin the literal values.
module tb_hilo_md_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mdOp = 2'b00;
  logic [W-1:0]  regaData = '0, regbData = '0;
  logic          whi = 1'b0, wlo = 1'b0;
  logic [W-1:0]  wHiData = '0, wLoData = '0;
  logic          cancel = 1'b0;
  logic          stall, done, divZero;
  logic [W-1:0]  rHiData, rLoData;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  hilo_md_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mdOp(mdOp),
    .regaData(regaData), .regbData(regbData),
    .whi(whi), .wlo(wlo), .wHiData(wHiData), .wLoData(wLoData),
    .cancel(cancel), .stall(stall), .done(done), .divZero(divZero),
    .rHiData(rHiData), .rLoData(rLoData), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'b0, a} * {32'b0, b};
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      default: res = {a % b, a / b};
    endcase
    return res;
  endfunction

  // Behavioural model. m_cnt counts the busy cycles left. A value of 1 means the completion cycle.
  int           m_cnt = 0;
  bit           m_zero = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;

  always @(posedge clk or posedge rst) begin
    logic [63:0] res;
    if (rst) begin
      m_cnt = 0; m_zero = 1'b0; m_hi = '0; m_lo = '0;
    end else if (m_cnt == 0) begin
      if (whi) m_hi = wHiData;
      if (wlo) m_lo = wLoData;
      if (start) begin
        if (mdOp[1] && regbData == '0) begin
          m_zero = 1'b1; m_cnt = 1;
        end else begin
          res = ref_result(mdOp, regaData, regbData);
          r_hi = res[63:32]; r_lo = res[31:0];
          m_zero = 1'b0; m_cnt = W + 1;
        end
      end
    end else if (cancel) begin
      m_cnt = 0;
    end else if (m_cnt == 1) begin
      if (!m_zero) begin m_hi = r_hi; m_lo = r_lo; end
      m_cnt = 0;
    end else begin
      m_cnt--;
    end
  end

  // Compare the DUT against the model on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("stall",   32'(stall),   32'(m_cnt != 0));
      check("done",    32'(done),    32'(m_cnt == 1 && !cancel));
      check("divZero", 32'(divZero), 32'(m_cnt == 1 && !cancel && m_zero));
      check("hi",      rHiData, m_hi);
      check("lo",      rLoData, m_lo);
    end
  end

  // Driver: present one operation, optionally with a same-cycle HI write.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic wh, input logic [W-1:0] hv);
    @(negedge clk);
    #1;
    start = 1'b1; mdOp = op; regaData = a; regbData = b;
    whi = wh; wHiData = hv;
  endtask

  // Run until stall drops. Record the done latency, the stall length, divZero and HI on the first cycle.
  task automatic wait_op(output int lat, output int st, output bit dz, output logic [W-1:0] hi1);
    lat = 0; st = 0; dz = 1'b0; hi1 = '0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 1) hi1 = rHiData;
      if (stall) st++;
      if (done && lat == 0) begin lat = i; dz = divZero; end
      #1;
      start = 1'b0; whi = 1'b0; wlo = 1'b0;
      if (!stall) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_op: timeout, stall still 1 after 80 cycles");
  endtask

  task automatic run_check(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_hi,
                           input logic [W-1:0] exp_lo, input bit exp_dz);
    int lat, st;
    bit dz;
    logic [W-1:0] hi1;
    start_op(op, a, b, 1'b0, '0);
    wait_op(lat, st, dz, hi1);
    check({name, "_lat"},   32'(lat), 32'(exp_lat));
    check({name, "_stall"}, 32'(st),  32'(exp_lat));
    check({name, "_dz"},    32'(dz),  32'(exp_dz));
    check({name, "_hi"},    rHiData, exp_hi);
    check({name, "_lo"},    rLoData, exp_lo);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return W'($urandom_range(1, 20));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int lat, st, done_seen, stall_seen;
    bit dz;
    logic [W-1:0] hi1;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_dz",    32'(divZero), 32'd0);
    check("rst_hi",    rHiData, '0);
    check("rst_lo",    rLoData, '0);
    #1 rst = 1'b0;

    // Multiply and divide with literal results.
    run_check("mult",   2'b00, 32'hFFFF_FFFF, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_check("multu",  2'b01, 32'hFFFF_FFFF, 32'h2, 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_check("div_n7", 2'b10, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_check("divu7",  2'b11, 32'h7,         32'h2, 33, 32'h1,         32'h3,         1'b0);
    run_check("div_min",2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0);

    // Preload HI/LO in one cycle, then divide by zero.
    @(negedge clk);
    #1 whi = 1'b1; wlo = 1'b1; wHiData = 32'h11; wLoData = 32'h22;
    @(negedge clk);
    check("preload_hi", rHiData, 32'h11);
    check("preload_lo", rLoData, 32'h22);
    #1 whi = 1'b0; wlo = 1'b0;
    run_check("divz", 2'b10, 32'h5, 32'h0, 1, 32'h11, 32'h22, 1'b1);

    // Cancel at iteration 10. A stray start and whi in cycle 5 must be ignored.
    start_op(2'b00, 32'd5, 32'd9, 1'b0, '0);
    done_seen = 0; stall_seen = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (i == 11) check("cancel_idle", 32'(stall), 32'd0);
      if (i > 11 && stall) stall_seen++;
      #1;
      case (i)
        1:  start = 1'b0;
        5:  begin start = 1'b1; mdOp = 2'b00; regaData = 32'd100; regbData = 32'd100;
                  whi = 1'b1; wHiData = 32'hDEAD; end
        6:  begin start = 1'b0; whi = 1'b0; end
        10: cancel = 1'b1;
        11: cancel = 1'b0;
        default: ;
      endcase
    end
    check("cancel_no_done",  32'(done_seen),  32'd0);
    check("cancel_no_stall", 32'(stall_seen), 32'd0);
    check("cancel_hi", rHiData, 32'h11);
    check("cancel_lo", rLoData, 32'h22);

    // Same-cycle whi and start.
    start_op(2'b00, 32'd3, 32'd4, 1'b1, 32'hAA);
    wait_op(lat, st, dz, hi1);
    check("same_hi_first", hi1, 32'hAA);
    check("same_lat", 32'(lat), 32'd33);
    check("same_hi", rHiData, 32'h0);
    check("same_lo", rLoData, 32'd12);

    // Reset in the middle of a divide.
    start_op(2'b11, 32'd1000, 32'd7, 1'b0, '0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      #1 start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("mrst_stall", 32'(stall),   32'd0);
    check("mrst_done",  32'(done),    32'd0);
    check("mrst_dz",    32'(divZero), 32'd0);
    check("mrst_hi",    rHiData, '0);
    check("mrst_lo",    rLoData, '0);
    @(negedge clk);
    #1 rst = 1'b0;
    run_check("after_rst", 2'b00, 32'd6, 32'd7, 33, 32'h0, 32'd42, 1'b0);

    // Random traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      start    = ($urandom_range(0, 3) == 0);
      mdOp     = 2'($urandom_range(0, 3));
      regaData = rand_opnd();
      regbData = rand_opnd();
      whi      = ($urandom_range(0, 9) == 0);
      wlo      = ($urandom_range(0, 9) == 0);
      wHiData  = W'($urandom);
      wLoData  = W'($urandom);
      cancel   = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    #1;
    start = 1'b0; whi = 1'b0; wlo = 1'b0; cancel = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
